allpass_config_sequencer: RTL and testbench

ALLPASS_CONFIG_SEQUENCER -- requirements
Module: allpass_config_sequencer

---
 rtl/reverb_pkg.sv | 28 ++
 rtl/cfg_saturate.sv | 38 +++
 rtl/allpass_config_sequencer.sv | 164 ++++++++++++++++
 tb/tb_allpass_config_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reverb_pkg.sv
// Constants shared by the reverb allpass configuration path:
// sequencer state codes, default slot count and fixed-point gain limits.
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 4096
`endif

package reverb_pkg;

    localparam int DEFAULT_N_FILTERS = 4;
    localparam int FRAC_BITS         = `FIXED_POINT;
    localparam int MAX_TAU           = `MAX_FILTER_FIFO_LENGTH;

    // Largest magnitude a gain may carry: 1.0 minus one LSB.
    localparam longint GAIN_LIMIT = (longint'(1) << FRAC_BITS) - 1;
    localparam longint GAIN_FLOOR = -GAIN_LIMIT;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_TICK = 3'd1;
    localparam state_t ST_SETUP     = 3'd2;
    localparam state_t ST_STROBE    = 3'd3;
    localparam state_t ST_HOLD      = 3'd4;

endpackage

// File: rtl/cfg_saturate.sv
// Conditions a host config beat before it reaches the shadow registers:
// delay length clamped to [1, MAX_TAU], gain saturated to just inside +/-1.0.
module cfg_saturate
    import reverb_pkg::*;
#(
    parameter int WORD = 40
)
(
    input  logic [WORD-1:0] tau_raw,
    input  logic [WORD-1:0] gain_raw,
    output logic [WORD-1:0] tau_sat,
    output logic [WORD-1:0] gain_sat
);

    localparam logic [WORD-1:0]        TAU_MAX = WORD'(MAX_TAU);
    localparam logic signed [WORD-1:0] GAIN_HI = WORD'(GAIN_LIMIT);
    localparam logic signed [WORD-1:0] GAIN_LO = WORD'(GAIN_FLOOR);

    // A zero-length delay line cannot exist, so the shortest legal tap is 1.
    always_comb begin
        tau_sat = tau_raw;
        if (tau_raw == '0) begin
            tau_sat = WORD'(1);
        end else if (tau_raw > TAU_MAX) begin
            tau_sat = TAU_MAX;
        end
    end

    always_comb begin
        gain_sat = gain_raw;
        if ($signed(gain_raw) > GAIN_HI) begin
            gain_sat = GAIN_HI;
        end else if ($signed(gain_raw) < GAIN_LO) begin
            gain_sat = GAIN_LO;
        end
    end

endmodule

// File: rtl/allpass_config_sequencer.sv
// Collects per-slot allpass settings from the host into shadow registers and,
// after a commit, pushes every dirty slot to the filters at the next sample tick.
module allpass_config_sequencer
    import reverb_pkg::*;
#(
    parameter int  N_FILTERS = DEFAULT_N_FILTERS,
    parameter int  WIDTH     = 24,
    localparam int WORD      = WIDTH + FRAC_BITS,
    localparam int IDX_W     = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1
)
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sample_tick,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [IDX_W-1:0]                cfg_index,
    input  logic [WORD-1:0]                 cfg_tau,
    input  logic [WORD-1:0]                 cfg_gain,
    input  logic                            cfg_commit,
    output logic [N_FILTERS-1:0][WORD-1:0]  tau_out,
    output logic [N_FILTERS-1:0][WORD-1:0]  gain_out,
    output logic [N_FILTERS-1:0]            write_out,
    output logic                            busy
);

    state_t                          state;
    logic [IDX_W-1:0]                idx;
    logic                            strobe_second;
    logic [N_FILTERS-1:0]            dirty;
    logic [N_FILTERS-1:0][WORD-1:0]  shadow_tau;
    logic [N_FILTERS-1:0][WORD-1:0]  shadow_gain;

    logic [WORD-1:0]                 tau_sat;
    logic [WORD-1:0]                 gain_sat;
    logic                            beat_take;
    logic                            beat_in_range;
    logic [N_FILTERS-1:0]            pending;
    logic [IDX_W-1:0]                next_idx;
    logic                            next_found;
    logic                            load_slot;

    cfg_saturate #(
        .WORD (WORD)
    ) u_saturate (
        .tau_raw  (cfg_tau),
        .gain_raw (cfg_gain),
        .tau_sat  (tau_sat),
        .gain_sat (gain_sat)
    );

    assign busy          = (state != ST_IDLE);
    assign cfg_ready     = !busy;
    assign beat_take     = cfg_valid && cfg_ready;
    assign beat_in_range = (int'(cfg_index) < N_FILTERS);

    // In HOLD the slot just written still reads dirty until this edge clears it.
    always_comb begin
        pending = dirty;
        if (state == ST_HOLD) begin
            pending[idx] = 1'b0;
        end
    end

    always_comb begin
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = N_FILTERS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                next_idx   = IDX_W'(i);
                next_found = 1'b1;
            end
        end
    end

    assign load_slot = ((state == ST_WAIT_TICK) && sample_tick) ||
                       ((state == ST_HOLD) && next_found);

    always_ff @(posedge clk) begin
        if (rst) begin
            dirty <= '0;
            for (int i = 0; i < N_FILTERS; i++) begin
                shadow_tau[i]  <= WORD'(1);
                shadow_gain[i] <= '0;
            end
        end else begin
            if (state == ST_HOLD) begin
                dirty[idx] <= 1'b0;
            end
            if (beat_take && beat_in_range) begin
                shadow_tau[cfg_index]  <= tau_sat;
                shadow_gain[cfg_index] <= gain_sat;
                dirty[cfg_index]       <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= '0;
            strobe_second <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_commit && (dirty != '0)) begin
                        state <= ST_WAIT_TICK;
                    end
                end
                ST_WAIT_TICK: begin
                    if (sample_tick) begin
                        state <= ST_SETUP;
                        idx   <= next_idx;
                    end
                end
                ST_SETUP: begin
                    state         <= ST_STROBE;
                    strobe_second <= 1'b0;
                end
                ST_STROBE: begin
                    if (strobe_second) begin
                        state <= ST_HOLD;
                    end
                    strobe_second <= 1'b1;
                end
                ST_HOLD: begin
                    if (next_found) begin
                        state <= ST_SETUP;
                        idx   <= next_idx;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Slot values are presented on entry to SETUP so they are settled a full
    // clock before the strobe rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_out <= '0;
            for (int i = 0; i < N_FILTERS; i++) begin
                tau_out[i]  <= WORD'(1);
                gain_out[i] <= '0;
            end
        end else begin
            if (load_slot) begin
                tau_out[next_idx]  <= shadow_tau[next_idx];
                gain_out[next_idx] <= shadow_gain[next_idx];
            end
            if (state == ST_SETUP) begin
                write_out      <= '0;
                write_out[idx] <= 1'b1;
            end else if ((state == ST_STROBE) && strobe_second) begin
                write_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_allpass_config_sequencer.sv
// Self-checking bench for allpass_config_sequencer: a queue-based reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_allpass_config_sequencer;
    import reverb_pkg::*;

    localparam int N     = 4;
    localparam int WIDTH = 24;
    localparam int WORD  = WIDTH + FRAC_BITS;
    localparam int IW    = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    sample_tick;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [IW-1:0]           cfg_index;
    logic [WORD-1:0]         cfg_tau;
    logic [WORD-1:0]         cfg_gain;
    logic                    cfg_commit;
    logic [N-1:0][WORD-1:0]  tau_out;
    logic [N-1:0][WORD-1:0]  gain_out;
    logic [N-1:0]            write_out;
    logic                    busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    allpass_config_sequencer #(
        .N_FILTERS (N),
        .WIDTH     (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_index   (cfg_index),
        .cfg_tau     (cfg_tau),
        .cfg_gain    (cfg_gain),
        .cfg_commit  (cfg_commit),
        .tau_out     (tau_out),
        .gain_out    (gain_out),
        .write_out   (write_out),
        .busy        (busy)
    );

    task automatic check_output(input string name, input logic [WORD-1:0] actual,
                                input logic [WORD-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: outputs follow from the sweep plan, one entry per clock.
    longint m_shadow_tau[N];
    longint m_shadow_gain[N];
    longint m_tau[N];
    longint m_gain[N];
    bit     m_dirty[N];
    bit     m_waiting;
    int     plan_slot[$];
    int     plan_phase[$];
    bit     model_live = 1'b0;

    function automatic longint sat_tau(input logic [WORD-1:0] t);
        longint v = longint'(t);
        if (v == 0) return 1;
        if (v > MAX_TAU) return MAX_TAU;
        return v;
    endfunction

    function automatic longint sat_gain(input logic [WORD-1:0] g);
        longint v   = longint'($signed(g));
        longint lim = (longint'(1) << FRAC_BITS) - 1;
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic bit any_dirty();
        for (int s = 0; s < N; s++) if (m_dirty[s]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N; s++) begin
                m_shadow_tau[s]  = 1;
                m_shadow_gain[s] = 0;
                m_tau[s]         = 1;
                m_gain[s]        = 0;
                m_dirty[s]       = 1'b0;
            end
            m_waiting = 1'b0;
            plan_slot.delete();
            plan_phase.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            if (plan_slot.size() > 0) begin
                if (plan_phase[0] == 3) m_dirty[plan_slot[0]] = 1'b0;
                void'(plan_slot.pop_front());
                void'(plan_phase.pop_front());
                if (plan_slot.size() > 0 && plan_phase[0] == 0) begin
                    m_tau[plan_slot[0]]  = m_shadow_tau[plan_slot[0]];
                    m_gain[plan_slot[0]] = m_shadow_gain[plan_slot[0]];
                end
            end else if (m_waiting) begin
                if (sample_tick) begin
                    m_waiting = 1'b0;
                    for (int s = 0; s < N; s++) begin
                        if (m_dirty[s]) begin
                            for (int k = 0; k < 4; k++) begin
                                plan_slot.push_back(s);
                                plan_phase.push_back(k);
                            end
                        end
                    end
                    m_tau[plan_slot[0]]  = m_shadow_tau[plan_slot[0]];
                    m_gain[plan_slot[0]] = m_shadow_gain[plan_slot[0]];
                end
            end else begin
                if (cfg_commit && any_dirty()) m_waiting = 1'b1;
                if (cfg_valid && int'(cfg_index) < N) begin
                    m_shadow_tau[cfg_index]  = sat_tau(cfg_tau);
                    m_shadow_gain[cfg_index] = sat_gain(cfg_gain);
                    m_dirty[cfg_index]       = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            logic         exp_busy;
            logic [N-1:0] exp_wr;
            exp_busy = m_waiting || (plan_slot.size() > 0);
            exp_wr   = '0;
            if (plan_slot.size() > 0 && (plan_phase[0] == 1 || plan_phase[0] == 2))
                exp_wr[plan_slot[0]] = 1'b1;
            check_output("busy", busy, exp_busy);
            check_output("cfg_ready", cfg_ready, !exp_busy);
            check_output("write_out", write_out, exp_wr);
            check_output("write_onehot", $countones(write_out) <= 1, 1'b1);
            for (int s = 0; s < N; s++) begin
                check_output($sformatf("tau_out[%0d]", s), tau_out[s], WORD'(m_tau[s]));
                check_output($sformatf("gain_out[%0d]", s), gain_out[s], WORD'(m_gain[s]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input int slot, input longint tau, input longint gain);
        cfg_valid = 1'b1;
        cfg_index = IW'(slot);
        cfg_tau   = WORD'(tau);
        cfg_gain  = WORD'(gain);
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        cfg_commit = 1'b1;
        step(1);
        cfg_commit = 1'b0;
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
    endtask

    initial begin
        int waited;
        rst = 1'b1; sample_tick = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0;
        cfg_index = '0; cfg_tau = '0; cfg_gain = '0;
        step(3);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_ready", cfg_ready, 1'b1);
        check_output("reset_tau1", tau_out[1], 40'd1);
        check_output("reset_gain1", gain_out[1], 40'd0);
        rst = 1'b0;
        step(1);

        $display("[TB] commit with nothing staged");
        pulse_commit();
        pulse_tick();
        step(3);
        check_output("empty_commit_busy", busy, 1'b0);
        check_output("empty_commit_write", write_out, 4'b0000);

        $display("[TB] single slot update");
        apply_stimulus(2, 100, 32768);
        pulse_commit();
        step(2);
        check_output("wait_tick_busy", busy, 1'b1);
        pulse_tick();
        check_output("setup_write_low", write_out, 4'b0000);
        check_output("setup_tau2", tau_out[2], 40'd100);
        step(1);
        check_output("strobe1_write", write_out, 4'b0100);
        check_output("strobe1_gain2", gain_out[2], 40'd32768);
        step(1);
        check_output("strobe2_write", write_out, 4'b0100);
        step(1);
        check_output("hold_write", write_out, 4'b0000);
        check_output("hold_busy", busy, 1'b1);
        step(1);
        check_output("done_busy", busy, 1'b0);

        $display("[TB] two slot sweep with stray tick");
        apply_stimulus(0, 200, 1000);
        apply_stimulus(3, 300, -1000);
        pulse_commit();
        pulse_tick();
        pulse_tick();
        check_output("sweep_slot0_write", write_out, 4'b0001);
        step(1);
        check_output("sweep_slot0_write2", write_out, 4'b0001);
        step(2);
        check_output("sweep_slot3_setup", write_out, 4'b0000);
        check_output("sweep_slot3_tau", tau_out[3], 40'd300);
        step(1);
        check_output("sweep_slot3_write", write_out, 4'b1000);
        step(3);
        check_output("sweep_done_busy", busy, 1'b0);
        check_output("sweep_tau0_kept", tau_out[0], 40'd200);

        $display("[TB] clamp and saturate");
        apply_stimulus(0, 0, 0);
        apply_stimulus(1, MAX_TAU + 5, 0);
        apply_stimulus(2, 10, 98304);
        apply_stimulus(3, 10, -131072);
        pulse_commit();
        pulse_tick();
        step(20);
        check_output("clamp_tau_zero", tau_out[0], 40'd1);
        check_output("clamp_tau_max", tau_out[1], WORD'(MAX_TAU));
        check_output("sat_gain_pos", gain_out[2], 40'd65535);
        check_output("sat_gain_neg", gain_out[3], 40'hFF_FFFF_0001);

        $display("[TB] beat held while busy");
        apply_stimulus(1, 50, 10);
        pulse_commit();
        cfg_valid = 1'b1; cfg_index = 2'd0; cfg_tau = 40'd77; cfg_gain = 40'd7;
        step(1);
        check_output("stall_ready", cfg_ready, 1'b0);
        pulse_commit();
        pulse_tick();
        waited = 0;
        while (!cfg_ready && waited < 40) begin
            step(1);
            waited++;
        end
        check_output("ready_after_sweep", waited, 4);
        step(1);
        cfg_valid = 1'b0;
        pulse_commit();
        pulse_tick();
        check_output("stalled_beat_tau", tau_out[0], 40'd77);
        step(6);

        $display("[TB] reset during strobe");
        apply_stimulus(1, 60, 3);
        apply_stimulus(2, 70, 4);
        pulse_commit();
        pulse_tick();
        step(1);
        check_output("pre_reset_write", write_out, 4'b0010);
        rst = 1'b1;
        step(1);
        check_output("abort_write", write_out, 4'b0000);
        check_output("abort_tau1", tau_out[1], 40'd1);
        check_output("abort_gain1", gain_out[1], 40'd0);
        check_output("abort_busy", busy, 1'b0);
        rst = 1'b0;
        step(1);
        pulse_commit();
        pulse_tick();
        step(3);
        check_output("post_abort_busy", busy, 1'b0);
        check_output("post_abort_write", write_out, 4'b0000);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
